// File: rtl/cpu_sram_arbiter.sv
// Two-into-one SRAM-like port arbiter between the instruction-fetch and data-memory ports.
// One transaction may be outstanding at a time. Data wins over inst when both are waiting
// in IDLE. An instruction fetch can be cancelled; its response is then absorbed here.
module cpu_sram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_cancel,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StWait
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnInst,
        OwnData
    } owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic   drop_q, drop_d;

    logic in_addr;
    logic in_wait;
    logic own_inst;
    logic own_data;
    logic cancel_hit;

    // Qualified phase/owner decodes; reset forces every handshake low in the same cycle.
    always_comb begin
        in_addr    = !reset && (state_q == StAddr);
        in_wait    = !reset && (state_q == StWait);
        own_inst   = (owner_q == OwnInst);
        own_data   = (owner_q == OwnData);
        cancel_hit = inst_cancel && own_inst && (state_q != StIdle);
    end

    // State, owner and drop-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state: grant in IDLE, hold owner through ADDR, release on data_ok in WAIT.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        case (state_q)
            StIdle: begin
                if (data_sram_req) begin
                    owner_d = OwnData;
                    state_d = StAddr;
                end else if (inst_sram_req) begin
                    owner_d = OwnInst;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                // The address phase cannot be withdrawn; a cancel only marks the response.
                if (cancel_hit) begin
                    drop_d = 1'b1;
                end
                if (sram_addr_ok) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cancel_hit) begin
                    drop_d = 1'b1;
                end
                if (sram_data_ok) begin
                    state_d = StIdle;
                    owner_d = OwnNone;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OwnNone;
                drop_d  = 1'b0;
            end
        endcase
    end

    // Master-side request: fields come from the owner only while the address is offered.
    always_comb begin
        sram_req   = in_addr;
        sram_wr    = 1'b0;
        sram_size  = 2'b00;
        sram_wstrb = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (in_addr && own_data) begin
            sram_wr    = data_sram_wr;
            sram_size  = data_sram_size;
            sram_wstrb = data_sram_wstrb;
            sram_addr  = data_sram_addr;
            sram_wdata = data_sram_wdata;
        end else if (in_addr && own_inst) begin
            sram_wr    = inst_sram_wr;
            sram_size  = inst_sram_size;
            sram_wstrb = inst_sram_wstrb;
            sram_addr  = inst_sram_addr;
            sram_wdata = inst_sram_wdata;
        end
    end

    // Slave-side handshakes routed back to the owner; a same-cycle cancel also suppresses.
    always_comb begin
        inst_sram_addr_ok = in_addr && own_inst && sram_addr_ok;
        data_sram_addr_ok = in_addr && own_data && sram_addr_ok;
        inst_sram_data_ok = in_wait && own_inst && sram_data_ok && !drop_q && !inst_cancel;
        data_sram_data_ok = in_wait && own_data && sram_data_ok;
        inst_sram_rdata   = sram_rdata;
        data_sram_rdata   = sram_rdata;
    end

endmodule
